ysyx_22050854_mul_ctrl: RTL and testbench

Issue/collect controller on the EXU side of the Booth multiplier handshake. It accepts one RV64M multiply op (MUL/MULH/MULHSU/MULHU/MULW) from the execute stage and drives the multiplier's mul_valid/operand/mulw/mul_signed inputs. It captures the one-cycle out_valid result pulse, selects hi or lo, and holds the result for writeback under a valid/ready handshake. It also handles pipeline flush, including draining an in-flight multiply.

---
 rtl/ysyx_22050854_mul_pkg.sv | 27 ++
 rtl/ysyx_22050854_mul_decode.sv | 24 ++
 rtl/ysyx_22050854_mul_ctrl.sv | 121 ++++++++++++
 tb/tb_ysyx_22050854_mul_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050854_mul_pkg.sv
// Shared types and constants for the RV64M multiply issue/collect controller.
package ysyx_22050854_mul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } mul_state_e;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;

  localparam logic [1:0] MUL_SIGNED_SS = 2'b11;
  localparam logic [1:0] MUL_SIGNED_SU = 2'b10;
  localparam logic [1:0] MUL_SIGNED_UU = 2'b00;

  typedef struct packed {
    logic       mulw;
    logic [1:0] mul_signed;
    logic       sel_hi;
  } mul_dec_t;

endpackage

// File: rtl/ysyx_22050854_mul_decode.sv
// Combinational funct3/word decoder producing multiplier control and hi/lo select.
module ysyx_22050854_mul_decode
  import ysyx_22050854_mul_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       word,
  output mul_dec_t   dec
);

  always_comb begin
    dec = '{mulw: 1'b0, mul_signed: MUL_SIGNED_SS, sel_hi: 1'b0};
    if (word) begin
      dec.mulw = 1'b1;
    end else begin
      case (funct3)
        MULH_F3:   dec.sel_hi = 1'b1;
        MULHSU_F3: begin dec.mul_signed = MUL_SIGNED_SU; dec.sel_hi = 1'b1; end
        MULHU_F3:  begin dec.mul_signed = MUL_SIGNED_UU; dec.sel_hi = 1'b1; end
        default:   dec.sel_hi = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22050854_mul_ctrl.sv
// EXU-side issue/collect controller for the Booth multiplier handshake.
// Optional MUL_CTRL_ZERO_BYPASS_EN: ops with a zero source skip the multiplier.
module ysyx_22050854_mul_ctrl
  import ysyx_22050854_mul_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_funct3,
  input  logic             op_word,
  input  logic [XLEN-1:0]  op_rs1,
  input  logic [XLEN-1:0]  op_rs2,
  input  logic [TAG_W-1:0] op_rd,
  input  logic             flush_in,
  output logic             mul_valid,
  output logic             mul_flush,
  output logic             mulw,
  output logic [1:0]       mul_signed,
  output logic [XLEN-1:0]  multiplicand,
  output logic [XLEN-1:0]  multiplier,
  input  logic             mul_ready,
  input  logic             mul_doing,
  input  logic             out_valid,
  input  logic [XLEN-1:0]  result_hi,
  input  logic [XLEN-1:0]  result_lo,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [XLEN-1:0]  wb_data,
  output logic [TAG_W-1:0] wb_rd
);

  mul_state_e state;
  mul_dec_t   dec;
  logic       sel_hi;
  logic       zero_op;

  ysyx_22050854_mul_decode u_decode (
    .funct3 (op_funct3),
    .word   (op_word),
    .dec    (dec)
  );

`ifdef MUL_CTRL_ZERO_BYPASS_EN
  assign zero_op = (op_rs1 == '0) || (op_rs2 == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign op_ready  = (state == IDLE) && !flush_in && !reset;
  assign mul_flush = flush_in && (state inside {ISSUE, WAIT, DRAIN});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mul_valid    <= 1'b0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
      mulw         <= 1'b0;
      mul_signed   <= '0;
      sel_hi       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid && op_ready) begin
            multiplicand <= op_rs1;
            multiplier   <= op_rs2;
            wb_rd        <= op_rd;
            mulw         <= dec.mulw;
            mul_signed   <= dec.mul_signed;
            sel_hi       <= dec.sel_hi;
            if (zero_op) begin
              wb_data  <= '0;
              wb_valid <= 1'b1;
              state    <= HOLD;
            end else begin
              mul_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // A flush in the accept cycle leaves the multiplier busy, so it must drain.
          if (flush_in) begin
            mul_valid <= 1'b0;
            state     <= mul_ready ? DRAIN : IDLE;
          end else if (mul_ready) begin
            mul_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (flush_in) begin
            state <= out_valid ? IDLE : DRAIN;
          end else if (out_valid) begin
            wb_data  <= sel_hi ? result_hi : result_lo;
            wb_valid <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (flush_in || wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        DRAIN: begin
          if (mul_ready && !mul_doing) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_mul_ctrl.sv
// Randomized bench for ysyx_22050854_mul_ctrl with a behavioural multiplier and reference model.
module tb_ysyx_22050854_mul_ctrl;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic             op_valid, op_ready, op_word, flush_in;
  logic [2:0]       op_funct3;
  logic [XLEN-1:0]  op_rs1, op_rs2;
  logic [TAG_W-1:0] op_rd;
  logic             mul_valid, mul_flush, mulw;
  logic [1:0]       mul_signed;
  logic [XLEN-1:0]  multiplicand, multiplier;
  logic             mul_ready, mul_doing, out_valid;
  logic [XLEN-1:0]  result_hi, result_lo;
  logic             wb_valid, wb_ready;
  logic [XLEN-1:0]  wb_data;
  logic [TAG_W-1:0] wb_rd;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  ysyx_22050854_mul_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_funct3(op_funct3), .op_word(op_word),
    .op_rs1(op_rs1), .op_rs2(op_rs2), .op_rd(op_rd), .flush_in(flush_in),
    .mul_valid(mul_valid), .mul_flush(mul_flush), .mulw(mulw), .mul_signed(mul_signed),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .mul_ready(mul_ready), .mul_doing(mul_doing), .out_valid(out_valid),
    .result_hi(result_hi), .result_lo(result_lo),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural multiplier: random latency, optional flush obedience, ready/stall.
  logic       busy;
  logic [7:0] cnt;
  logic [127:0] prod_q;
  int   viol = 0;
  logic honor_flush = 1'b1;
  int   stall_mode = 0;
  logic stall = 1'b0;

  assign mul_ready = !busy && !stall;
  assign mul_doing = busy;

  always @(negedge clock)
    stall = (stall_mode == 2) || (stall_mode == 1 && $urandom_range(0, 3) == 0);

  function automatic logic [127:0] mult_model(input logic [1:0] sg, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    ea = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
    eb = sg[0] ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ea * eb;
    if (w) p = {p[127:64], {32{p[31]}}, p[31:0]};
    return p;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= 1'b0; out_valid <= 1'b0; cnt <= '0; result_hi <= '0; result_lo <= '0;
    end else begin
      out_valid <= 1'b0;
      if (mul_valid && busy) viol <= viol + 1;
      if (mul_flush && honor_flush) busy <= 1'b0;
      else if (busy) begin
        if (cnt == 0) begin
          busy <= 1'b0; out_valid <= 1'b1; {result_hi, result_lo} <= prod_q;
        end else cnt <= cnt - 8'd1;
      end else if (mul_valid && mul_ready) begin
        busy   <= 1'b1;
        cnt    <= 8'($urandom_range(0, 4));
        prod_q <= mult_model(mul_signed, mulw, multiplicand, multiplier);
      end
    end
  end

  int   wb_pulses = 0;
  logic wb_prev = 1'b0;
  always @(negedge clock) begin
    if (wb_valid && !wb_prev) wb_pulses++;
    wb_prev = wb_valid;
  end

  // Reference: architectural RV64M results straight from funct3/word.
  function automatic logic [63:0] ref_mul(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  q;
    if (w) begin
      q = a[31:0] * b[31:0];
      return {{32{q[31]}}, q};
    end
    case (f3)
      3'b001:  begin p = $signed(a) * $signed(b);         return p[127:64]; end
      3'b010:  begin p = $signed(a) * $signed({1'b0, b}); return p[127:64]; end
      3'b011:  begin p = a * b;                           return p[127:64]; end
      default: begin p = a * b;                           return p[63:0];   end
    endcase
  endfunction

  function automatic logic [1:0] ref_signed(input logic [2:0] f3, input logic w);
    if (w) return 2'b11;
    if (f3 == 3'b010) return 2'b10;
    if (f3 == 3'b011) return 2'b00;
    return 2'b11;
  endfunction

  function automatic logic ref_bypass(input logic [63:0] a, input logic [63:0] b);
`ifdef MUL_CTRL_ZERO_BYPASS_EN
    return (a == 0) || (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Presents an op and returns at the negedge right after it was accepted.
  task automatic issue_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, output logic ok);
    int n = 0;
    @(negedge clock);
    op_valid = 1'b1; op_funct3 = f3; op_word = w; op_rs1 = a; op_rs2 = b; op_rd = rd;
    while (!op_ready && n < 60) begin @(negedge clock); n++; end
    ok = op_ready;
    if (!ok) begin
      check("op_ready_timeout", 64'(op_ready), 64'd1);
      op_valid = 1'b0;
      return;
    end
    @(negedge clock);
    op_valid = 1'b0;
    op_funct3 = 3'($urandom); op_word = 1'($urandom);
    op_rs1 = {$urandom, $urandom}; op_rs2 = {$urandom, $urandom}; op_rd = 5'($urandom);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input int hold);
    logic [63:0] expv;
    logic ok, prev_ov;
    int n, p0;
    expv = ref_mul(f3, w, a, b);
    p0 = wb_pulses;
    issue_op(f3, w, a, b, rd, ok);
    if (!ok) return;
    if (ref_bypass(a, b)) begin
      check("byp_wb_valid", 64'(wb_valid), 64'd1);
      check("byp_mul_valid", 64'(mul_valid), 64'd0);
    end else begin
      check("iss_mul_valid", 64'(mul_valid), 64'd1);
      check("iss_signed", 64'(mul_signed), 64'(ref_signed(f3, w)));
      check("iss_mulw", 64'(mulw), 64'(w));
      check("iss_mcand", multiplicand, a);
      check("iss_mplier", multiplier, b);
      n = 0; prev_ov = 1'b0;
      while (!wb_valid && n < 100) begin prev_ov = out_valid; @(negedge clock); n++; end
      check("wb_valid_seen", 64'(wb_valid), 64'd1);
      check("wb_latency", 64'(prev_ov), 64'd1);
    end
    check("wb_data", wb_data, expv);
    check("wb_rd", 64'(wb_rd), 64'(rd));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_valid", 64'(wb_valid), 64'd1);
      check("hold_data", wb_data, expv);
      check("hold_rd", 64'(wb_rd), 64'(rd));
      check("hold_op_ready", 64'(op_ready), 64'd0);
      check("hold_mul_valid", 64'(mul_valid), 64'd0);
    end
    wb_ready = 1'b1;
    #1 check("hs_op_ready", 64'(op_ready), 64'd0);
    @(negedge clock);
    wb_ready = 1'b0;
    check("wb_release", 64'(wb_valid), 64'd0);
    check("wb_one_pulse", 64'(wb_pulses - p0), 64'd1);
  endtask

  initial begin
    logic ok;
    int p0, n;
    reset = 1'b1; op_valid = 1'b1; op_funct3 = '0; op_word = 1'b0;
    op_rs1 = 64'd5; op_rs2 = 64'd6; op_rd = 5'd3; flush_in = 1'b0; wb_ready = 1'b0;
    @(negedge clock); @(negedge clock);
    check("rst_op_ready", 64'(op_ready), 64'd0);
    check("rst_mul_valid", 64'(mul_valid), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    check("rst_mcand", multiplicand, 64'd0);
    check("rst_mplier", multiplier, 64'd0);
    op_valid = 1'b0;
    reset = 1'b0;

    run_op(3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd1, 0);
    run_op(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd2, 1);
    run_op(3'b011, 1'b0, '1, 64'd2, 5'd3, 0);
    run_op(3'b010, 1'b0, '1, 64'd2, 5'd4, 2);
    run_op(3'b000, 1'b0, 64'd11, 64'd13, 5'd5, 5);
    run_op(3'b000, 1'b0, 64'd77, 64'd0, 5'd6, 2);
    run_op(3'b001, 1'b0, 64'd0, 64'h8000_0000_0000_0000, 5'd7, 1);

    // Flush in WAIT while the multiplier keeps running, then a fresh op.
    honor_flush = 1'b0;
    p0 = wb_pulses;
    issue_op(3'b000, 1'b0, 64'd100, 64'd200, 5'd8, ok);
    @(negedge clock);
    flush_in = 1'b1;
    #1 check("flush_mul_flush", 64'(mul_flush), 64'd1);
    check("flush_op_ready", 64'(op_ready), 64'd0);
    @(negedge clock);
    flush_in = 1'b0;
    run_op(3'b000, 1'b0, 64'd6, 64'd7, 5'd9, 1);
    check("flush_pulses", 64'(wb_pulses - p0), 64'd1);
    check("drain_no_early_issue", 64'(viol), 64'd0);
    honor_flush = 1'b1;

    // Async reset while mul_valid is held (multiplier stalled).
    stall_mode = 2;
    issue_op(3'b000, 1'b0, 64'd9, 64'd9, 5'd10, ok);
    check("stall_mul_valid", 64'(mul_valid), 64'd1);
    #2 reset = 1'b1;
    #1 check("arst_mul_valid", 64'(mul_valid), 64'd0);
    check("arst_op_ready", 64'(op_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    stall_mode = 0;

    // Async reset while a result is held.
    issue_op(3'b000, 1'b0, 64'd4, 64'd5, 5'd11, ok);
    n = 0;
    while (!wb_valid && n < 100) begin @(negedge clock); n++; end
    check("pre_arst_wb_valid", 64'(wb_valid), 64'd1);
    #2 reset = 1'b1;
    #1 check("arst_wb_valid", 64'(wb_valid), 64'd0);
    check("arst_wb_data", wb_data, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    stall_mode = 1;
    for (int k = 0; k < 40; k++) begin
      run_op(3'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), rnd_operand(),
             rnd_operand(), 5'($urandom), $urandom_range(0, 3));
    end
    stall_mode = 0;
    check("final_viol", 64'(viol), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
